nvm_burst_reader: RTL and testbench
===================================

Name: nvm_burst_reader

Overview:
- Parametrised successor to the single-word serial NVM reader.
- Accepts a start command carrying a base address and a burst length.
- Fetches consecutive words from the NVM array over a 1-cycle-latency parallel read port, then serialises each word bit by bit onto a valid/ready serial stream.
- Sits between the NVM macro and the serial consumer (boot loader / config shifter).

Parameters:
DATA_W, 8, word width in bits (bits serialised per word)
ADDR_W, 8, NVM address width
LEN_W, 2, burst length field width; words per burst = burst_len+1 (1..2^LEN_W)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  command strobe, sampled only in IDLE
addr_in  input  ADDR_W  base address, captured with start
burst_len  input  LEN_W  words-1, captured with start
abort  input  1  terminate burst, return to IDLE
nvm_rd  output  1  read strobe to NVM, one cycle per word
nvm_addr  output  ADDR_W  NVM read address
nvm_rdata  input  DATA_W  NVM data, valid in cycle after nvm_rd
sdata_out  output  1  serial data bit
sdata_valid  output  1  sdata_out valid
sdata_ready  input  1  consumer accepts bit when valid&ready
address_out  output  ADDR_W  address of word currently being shifted
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after last bit of burst accepted

Behaviour:
- All outputs registered.
- Reset (async, immediate) sets state=IDLE; nvm_rd, nvm_addr, sdata_out, sdata_valid, address_out, busy, done, shift register, bit counter and word counter all =0.
- States: IDLE, FETCH, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 and abort=0: capture addr_in into cur_addr and burst_len into words_left -> FETCH.
  - Otherwise stay.
- FETCH (1 cycle): nvm_rd=1, nvm_addr=cur_addr -> LOAD.
- LOAD (1 cycle): capture nvm_rdata into the shift register at the closing edge. At the same edge: address_out<=cur_addr, bit count<=DATA_W-1 -> SHIFT.
- SHIFT:
  - sdata_valid=1.
  - sdata_out = current MSB (MSB_FIRST=1) or current LSB (MSB_FIRST=0).
  - Each cycle with sdata_ready=1: shift by one, decrement bit count.
  - sdata_ready=0: hold sdata_out, sdata_valid and all counters.
- Last bit accepted:
  - If words_left=0 -> DONE.
  - Else words_left-1, cur_addr+1 (mod 2^ADDR_W; 0xFF wraps to 0x00 for ADDR_W=8) -> FETCH.
  - sdata_valid drops for the 2 bubble cycles (FETCH, LOAD) between words.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency with sdata_ready held 1:
  - First bit valid 2 cycles after the start-sampling edge.
  - Each word occupies DATA_W+2 cycles.
  - done asserts in the cycle after the last bit.
- start while busy=1: ignored, no queuing.
- abort:
  - Highest priority after rst, effective in any non-IDLE state.
  - Next state IDLE; sdata_valid, nvm_rd and busy low next cycle; done NOT asserted.
  - address_out retains its last value.
  - start and abort in the same IDLE cycle: abort wins, command dropped.
- Reset mid-burst: all outputs go to reset values immediately, the burst is lost, and no done is produced.
- nvm_rdata is ignored outside LOAD.

Test Plan:
- Single word, MSB_FIRST=1, ready=1: start with addr_in=0xCC, burst_len=0, NVM[0xCC]=0xAA -> nvm_rd for 1 cycle with nvm_addr=0xCC; sdata_out=1,0,1,0,1,0,1,0 over 8 cycles starting 2 cycles after start; address_out=0xCC; done pulse on cycle 10; busy low after.
- LSB-first instance (MSB_FIRST=0), NVM[0x10]=0x01 -> bit sequence 1,0,0,0,0,0,0,0.
- Burst with wrap: addr_in=0xFF, burst_len=1, NVM[0xFF]=0xF0, NVM[0x00]=0x0F -> two nvm_rd strobes at 0xFF then 0x00; stream 11110000 then 00001111 with a 2-cycle valid gap; address_out 0xFF then 0x00; one done after 20 cycles.
- Backpressure: during the word 0xAA, hold sdata_ready=0 for 3 cycles after the 3rd bit -> sdata_out holds 1 and sdata_valid stays 1 for the stall; sequence intact; done delayed by exactly 3 cycles.
- Abort and ignored start: start a burst_len=3 burst, pulse start with a new address mid-shift (ignored), then abort during word 2 -> state IDLE next cycle, no done, no further nvm_rd.
- Reset: assert rst asynchronously mid-shift -> all outputs 0 before next clock edge; a new start after release completes normally.

Source files
------------

// File: rtl/nvm_burst_reader_if.sv
// Bundle of the command, NVM read port and serial stream signals of nvm_burst_reader.
// The slave modport is the reader itself; master is the surrounding system.
interface nvm_burst_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 2
);
  logic              start;
  logic [ADDR_W-1:0] addr_in;
  logic [LEN_W-1:0]  burst_len;
  logic              abort;
  logic              nvm_rd;
  logic [ADDR_W-1:0] nvm_addr;
  logic [DATA_W-1:0] nvm_rdata;
  logic              sdata_out;
  logic              sdata_valid;
  logic              sdata_ready;
  logic [ADDR_W-1:0] address_out;
  logic              busy;
  logic              done;

  modport master (
    output start, addr_in, burst_len, abort, nvm_rdata, sdata_ready,
    input  nvm_rd, nvm_addr, sdata_out, sdata_valid, address_out, busy, done
  );

  modport slave (
    input  start, addr_in, burst_len, abort, nvm_rdata, sdata_ready,
    output nvm_rd, nvm_addr, sdata_out, sdata_valid, address_out, busy, done
  );
endinterface

// File: rtl/nvm_burst_reader.sv
// Burst reader: fetches burst_len+1 consecutive NVM words through a 1-cycle-latency
// read port and serialises each word onto a valid/ready bit stream.
module nvm_burst_reader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  nvm_burst_reader_if.slave    bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [LEN_W-1:0]  words_left_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              nvm_rd_reg;
  logic [ADDR_W-1:0] nvm_addr_reg;
  logic              sdata_valid_reg;
  logic [ADDR_W-1:0] address_out_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [DATA_W-1:0] shift_next;
  logic              serial_bit;

  // The outgoing bit is always the end of the shift register that leaves first.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign serial_bit = shift_reg[DATA_W-1];
      assign shift_next = shift_reg << 1;
    end else begin : g_lsb_first
      assign serial_bit = shift_reg[0];
      assign shift_next = shift_reg >> 1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      cur_addr_reg    <= '0;
      words_left_reg  <= '0;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      nvm_rd_reg      <= 1'b0;
      nvm_addr_reg    <= '0;
      sdata_valid_reg <= 1'b0;
      address_out_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      nvm_rd_reg <= 1'b0;
      done_reg   <= 1'b0;
      if (bus.abort && (state_reg != S_IDLE)) begin
        // Abort drops the burst silently; address_out keeps the last word's address.
        state_reg       <= S_IDLE;
        sdata_valid_reg <= 1'b0;
        busy_reg        <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              cur_addr_reg   <= bus.addr_in;
              words_left_reg <= bus.burst_len;
              nvm_rd_reg     <= 1'b1;
              nvm_addr_reg   <= bus.addr_in;
              busy_reg       <= 1'b1;
              state_reg      <= S_FETCH;
            end
          end
          S_FETCH: begin
            state_reg <= S_LOAD;
          end
          S_LOAD: begin
            shift_reg       <= bus.nvm_rdata;
            address_out_reg <= cur_addr_reg;
            bit_cnt_reg     <= CNT_W'(DATA_W - 1);
            sdata_valid_reg <= 1'b1;
            state_reg       <= S_SHIFT;
          end
          S_SHIFT: begin
            if (bus.sdata_ready) begin
              shift_reg   <= shift_next;
              bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
              if (bit_cnt_reg == '0) begin
                sdata_valid_reg <= 1'b0;
                if (words_left_reg == '0) begin
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
                end else begin
                  // Next word: the read strobe is issued straight from the last-bit edge.
                  words_left_reg <= words_left_reg - LEN_W'(1);
                  cur_addr_reg   <= cur_addr_reg + ADDR_W'(1);
                  nvm_addr_reg   <= cur_addr_reg + ADDR_W'(1);
                  nvm_rd_reg     <= 1'b1;
                  state_reg      <= S_FETCH;
                end
              end
            end
          end
          S_DONE: begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
          default: begin
            sdata_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            state_reg       <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.nvm_rd      = nvm_rd_reg;
  assign bus.nvm_addr    = nvm_addr_reg;
  assign bus.sdata_out   = serial_bit;
  assign bus.sdata_valid = sdata_valid_reg;
  assign bus.address_out = address_out_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;

endmodule

// File: tb/tb_nvm_burst_reader.sv
// Bench for nvm_burst_reader: MSB-first and LSB-first instances run in lockstep against
// a transaction-level model, plus directed bursts with hand-computed expectations.
module tb_nvm_burst_reader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              sdata_ready = 1'b1;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rdata_m, rdata_l;

  nvm_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_m ();
  nvm_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_l ();

  assign bus_m.start = start;       assign bus_l.start = start;
  assign bus_m.abort = abort;       assign bus_l.abort = abort;
  assign bus_m.addr_in = addr_in;   assign bus_l.addr_in = addr_in;
  assign bus_m.burst_len = burst_len; assign bus_l.burst_len = burst_len;
  assign bus_m.sdata_ready = sdata_ready; assign bus_l.sdata_ready = sdata_ready;
  assign bus_m.nvm_rdata = rdata_m; assign bus_l.nvm_rdata = rdata_l;

  nvm_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MSB_FIRST(1'b1))
    dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  nvm_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MSB_FIRST(1'b0))
    dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  // NVM macro: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus_m.nvm_rd) rdata_m <= mem[bus_m.nvm_addr]; else rdata_m <= DATA_W'($urandom);
    if (bus_l.nvm_rd) rdata_l <= mem[bus_l.nvm_addr]; else rdata_l <= DATA_W'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic              e_rd = 1'b0, e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [ADDR_W-1:0] e_naddr = '0, e_aout = '0;
  logic [DATA_W-1:0] e_word = '0;
  int                e_bit = 0;
  bit                killed = 1'b0;

  task automatic zero_all();
    e_rd = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_naddr = '0; e_aout = '0;
  endtask

  task automatic step();
    @(posedge clk);
    killed = rst || abort;
    if (rst) zero_all();
    else if (abort) begin
      e_rd = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    killed = 1'b0;
    for (int w = 0; w <= int'(len) && !killed; w++) begin
      e_naddr = base + ADDR_W'(w);
      e_rd = 1'b1; e_busy = 1'b1; e_valid = 1'b0;
      step();
      if (killed) break;
      e_rd = 1'b0;
      step();
      if (killed) break;
      e_aout = e_naddr; e_word = mem[e_naddr]; e_valid = 1'b1;
      for (int b = 0; b < DATA_W && !killed; b++) begin
        e_bit = b;
        do step(); while (!killed && !sdata_ready);
      end
      if (!killed) e_valid = 1'b0;
    end
    if (!killed) begin
      e_done = 1'b1;
      step();
      if (!killed) begin e_done = 1'b0; e_busy = 1'b0; end
    end
  endtask

  initial begin
    forever begin
      do begin
        @(posedge clk);
        if (rst) zero_all();
      end while (rst || !(start && !abort));
      run_burst(addr_in, burst_len);
    end
  end

  // ---------------- per-cycle compare and monitor ----------------
  logic [15:0] cap_m = '0, cap_l = '0;
  int rd_cnt = 0, done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    check("nvm_rd_m", 16'(bus_m.nvm_rd), rst ? 16'd0 : 16'(e_rd));
    check("nvm_rd_l", 16'(bus_l.nvm_rd), rst ? 16'd0 : 16'(e_rd));
    check("nvm_addr_m", 16'(bus_m.nvm_addr), rst ? 16'd0 : 16'(e_naddr));
    check("nvm_addr_l", 16'(bus_l.nvm_addr), rst ? 16'd0 : 16'(e_naddr));
    check("valid_m", 16'(bus_m.sdata_valid), rst ? 16'd0 : 16'(e_valid));
    check("valid_l", 16'(bus_l.sdata_valid), rst ? 16'd0 : 16'(e_valid));
    check("addr_out_m", 16'(bus_m.address_out), rst ? 16'd0 : 16'(e_aout));
    check("addr_out_l", 16'(bus_l.address_out), rst ? 16'd0 : 16'(e_aout));
    check("busy_m", 16'(bus_m.busy), rst ? 16'd0 : 16'(e_busy));
    check("busy_l", 16'(bus_l.busy), rst ? 16'd0 : 16'(e_busy));
    check("done_m", 16'(bus_m.done), rst ? 16'd0 : 16'(e_done));
    check("done_l", 16'(bus_l.done), rst ? 16'd0 : 16'(e_done));
    if (!rst && e_valid) begin
      check("sdata_m", 16'(bus_m.sdata_out), 16'(e_word[DATA_W-1-e_bit]));
      check("sdata_l", 16'(bus_l.sdata_out), 16'(e_word[e_bit]));
    end
    if (bus_m.sdata_valid && sdata_ready) cap_m = {cap_m[14:0], bus_m.sdata_out};
    if (bus_l.sdata_valid && sdata_ready) cap_l = {cap_l[14:0], bus_l.sdata_out};
    if (bus_m.nvm_rd) rd_cnt++;
    if (bus_m.done) begin done_cnt++; done_cyc = cyc; end
  end

  // ---------------- directed helpers ----------------
  int t0 = 0, rd0 = 0, dn0 = 0;

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    rd0 = rd_cnt; dn0 = done_cnt;
    @(posedge clk); #2;
    start = 1'b1; addr_in = a; burst_len = len;
    @(posedge clk); #1;
    t0 = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int latency);
    int n;
    n = 0;
    while (done_cnt == dn0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == dn0) check({name, "_timeout"}, 16'd0, 16'd1);
    else check({name, "_latency"}, 16'(done_cyc - t0), 16'(latency));
  endtask

  task automatic check_zero(input string name);
    check({name, "_rd"},    16'({bus_m.nvm_rd, bus_l.nvm_rd}), 16'd0);
    check({name, "_naddr"}, 16'({bus_m.nvm_addr, bus_l.nvm_addr}), 16'd0);
    check({name, "_sdata"}, 16'({bus_m.sdata_out, bus_l.sdata_out}), 16'd0);
    check({name, "_valid"}, 16'({bus_m.sdata_valid, bus_l.sdata_valid}), 16'd0);
    check({name, "_aout"},  16'({bus_m.address_out, bus_l.address_out}), 16'd0);
    check({name, "_busy"},  16'({bus_m.busy, bus_l.busy}), 16'd0);
    check({name, "_done"},  16'({bus_m.done, bus_l.done}), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
    #1 check_zero("reset_state");
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;

    // single word, MSB and LSB first
    mem[8'hCC] = 8'hAA;
    issue(8'hCC, 2'd0);
    wait_done("single", 10);
    check("single_bits_m", cap_m & 16'h00FF, 16'h00AA);
    check("single_bits_l", cap_l & 16'h00FF, 16'h0055);
    check("single_rd_cnt", 16'(rd_cnt - rd0), 16'd1);
    check("single_aout", 16'(bus_m.address_out), 16'h00CC);
    @(negedge clk); #1 check("single_busy_after", 16'(bus_m.busy), 16'd0);
    $display("txn single addr=cc len=0 bits_m=%02h bits_l=%02h", cap_m[7:0], cap_l[7:0]);

    mem[8'h10] = 8'h01;
    issue(8'h10, 2'd0);
    wait_done("lsb", 10);
    check("lsb_bits_l", cap_l & 16'h00FF, 16'h0080);
    check("lsb_bits_m", cap_m & 16'h00FF, 16'h0001);
    $display("txn lsb addr=10 len=0 bits_l=%02h", cap_l[7:0]);

    // two-word burst wrapping the address space
    mem[8'hFF] = 8'hF0; mem[8'h00] = 8'h0F;
    issue(8'hFF, 2'd1);
    wait_done("wrap", 20);
    check("wrap_bits_m", cap_m, 16'hF00F);
    check("wrap_bits_l", cap_l, 16'h0FF0);
    check("wrap_rd_cnt", 16'(rd_cnt - rd0), 16'd2);
    check("wrap_aout", 16'(bus_m.address_out), 16'h0000);
    $display("txn wrap addr=ff len=1 bits_m=%04h", cap_m);

    // backpressure: stall 3 cycles while the third bit is presented
    issue(8'hCC, 2'd0);
    repeat (4) @(posedge clk);
    #2 sdata_ready = 1'b0;
    #3 check("stall_hold", 16'({bus_m.sdata_valid, bus_m.sdata_out}), 16'd3);
    repeat (3) @(posedge clk);
    #2 sdata_ready = 1'b1;
    wait_done("stall", 13);
    check("stall_bits_m", cap_m & 16'h00FF, 16'h00AA);
    $display("txn stall addr=cc len=0 bits_m=%02h", cap_m[7:0]);

    // ignored start mid-burst, then abort during word 2
    issue(8'h40, 2'd3);
    repeat (5) @(posedge clk);
    #2 start = 1'b1; addr_in = 8'h80;
    @(posedge clk); #2 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    #3 check("abort_busy", 16'(bus_m.busy), 16'd0);
    repeat (30) @(posedge clk);
    #1 check("abort_rd_cnt", 16'(rd_cnt - rd0), 16'd2);
    check("abort_no_done", 16'(done_cnt - dn0), 16'd0);
    check("abort_aout", 16'(bus_m.address_out), 16'h0041);
    $display("txn abort addr=40 len=3 rd=%0d done=%0d", rd_cnt - rd0, done_cnt - dn0);

    // start and abort together in IDLE: command dropped
    @(posedge clk); #2 start = 1'b1; abort = 1'b1;
    @(posedge clk); #2 start = 1'b0; abort = 1'b0;
    #3 check("start_abort_busy", 16'(bus_m.busy), 16'd0);
    $display("txn start+abort dropped busy=%0b", bus_m.busy);

    // asynchronous reset mid-shift, then a clean burst
    mem[8'h20] = 8'hAA;
    issue(8'h20, 2'd0);
    repeat (4) @(posedge clk);
    #7 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    mem[8'h21] = 8'h5A;
    issue(8'h21, 2'd0);
    wait_done("post_rst", 10);
    check("post_rst_bits_m", cap_m & 16'h00FF, 16'h005A);
    $display("txn reset-then addr=21 len=0 bits_m=%02h", cap_m[7:0]);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start       = ($urandom_range(0, 5) == 0);
      abort       = ($urandom_range(0, 49) == 0);
      sdata_ready = ($urandom_range(0, 3) != 0);
      addr_in     = ADDR_W'($urandom);
      burst_len   = LEN_W'($urandom);
    end
    @(posedge clk); #2 start = 1'b0; abort = 1'b0; sdata_ready = 1'b1;
    repeat (60) @(posedge clk);
    $display("txn random bursts_done=%0d reads=%0d", done_cnt, rd_cnt);
    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
